// File: rtl/uart_tx_arbiter_if.sv
// Requester streams, UART handshake and status of uart_tx_arbiter.
// master drives the requesters and tx_busy; slave is the arbiter side.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       arb_err;

  modport master (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    output tx_busy,
    input  tx_start, tx_data, grant, arb_err
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    input  tx_busy,
    output tx_start, tx_data, grant, arb_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding two byte streams into one UART transmitter.
// Define TX_ARB_TIMEOUT_EN to drop a granted requester that stalls for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, XFER, START, WAIT_HI, WAIT_LO} state_t;

  state_t     state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic       favour1_reg, favour1_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       last_reg, last_next;
  logic       tx_start_reg;
  logic       arb_err_reg, arb_err_next;
  logic       xfer_open;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       accept;
  logic       drop;

  if (TIMEOUT_CYC < 1) begin : g_timeout_range
    $error("TIMEOUT_CYC must be at least 1");
  end

  assign sel_valid = grant_reg[1] ? bus.req1_valid : bus.req0_valid;
  assign sel_last  = grant_reg[1] ? bus.req1_last  : bus.req0_last;
  assign sel_data  = grant_reg[1] ? bus.req1_data  : bus.req0_data;

  // Ready is combinational so a byte is taken the same cycle the UART goes idle.
  assign xfer_open      = (state_reg == XFER) && !bus.tx_busy && !rst;
  assign bus.req0_ready = xfer_open && grant_reg[0];
  assign bus.req1_ready = xfer_open && grant_reg[1];
  assign accept         = xfer_open && sel_valid;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             stall;

  assign stall = (state_reg == XFER) && !sel_valid;
  assign drop  = stall && (stall_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_reg != XFER) || accept || drop) begin
      stall_cnt_reg <= '0;
    end else if (stall) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    favour1_next = favour1_reg;
    tx_data_next = tx_data_reg;
    last_next    = last_reg;
    arb_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // Holding off while busy keeps a frame that survived reset from being overrun.
        if (!bus.tx_busy && (bus.req0_valid || bus.req1_valid)) begin
          if (bus.req0_valid && bus.req1_valid) begin
            grant_next = favour1_reg ? 2'b10 : 2'b01;
          end else begin
            grant_next = bus.req1_valid ? 2'b10 : 2'b01;
          end
          state_next = XFER;
        end
      end
      XFER: begin
        if (drop) begin
          arb_err_next = 1'b1;
          grant_next   = 2'b00;
          favour1_next = grant_reg[0];
          state_next   = IDLE;
        end else if (accept) begin
          tx_data_next = sel_data;
          last_next    = sel_last;
          state_next   = START;
        end
      end
      START: state_next = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_reg) begin
            state_next   = IDLE;
            grant_next   = 2'b00;
            favour1_next = grant_reg[0];
          end else begin
            state_next = XFER;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'b00;
      favour1_reg  <= 1'b0;
      tx_data_reg  <= 8'h00;
      last_reg     <= 1'b0;
      tx_start_reg <= 1'b0;
      arb_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      favour1_reg  <= favour1_next;
      tx_data_reg  <= tx_data_next;
      last_reg     <= last_next;
      tx_start_reg <= (state_next == START);
      arb_err_reg  <= arb_err_next;
    end
  end

  assign bus.tx_start = tx_start_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.grant    = grant_reg;
  assign bus.arb_err  = arb_err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random packets scored by a packet-level model.
// Define TX_ARB_TIMEOUT_EN to check the timeout drop instead of the indefinite hold.
module tb_uart_tx_arbiter;
  localparam int TO_CYC = 16;

  typedef struct packed { logic [7:0] data; logic last; } beat_t;
  // kind 0: grant taken from idle, 1: tx_start, 2: arb_err
  typedef struct { int kind; logic [1:0] grant; logic [7:0] data; logic v0; logic v1; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();
  uart_tx_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] drv_v = 2'b00;
  logic [7:0] drv_d [2];
  logic [1:0] drv_l = 2'b00;
  int         busy_cnt = 0;
  int         busy_len = 10;
  bit         busy_rand = 1'b0;
  int         gap_max = 0;

  assign bus.req0_valid = drv_v[0];
  assign bus.req0_data  = drv_d[0];
  assign bus.req0_last  = drv_l[0];
  assign bus.req1_valid = drv_v[1];
  assign bus.req1_data  = drv_d[1];
  assign bus.req1_last  = drv_l[1];
  assign bus.tx_busy    = (busy_cnt != 0);

  beat_t drv_q0[$], drv_q1[$], exp_q0[$], exp_q1[$];
  ev_t   ev_q[$];
  int    errors = 0, checks = 0;
  int    ready_bad = 0, lat_bad = 0, data_bad = 0, err_pulses = 0, tx_cnt = 0;
  logic  fav1 = 1'b0, in_pkt = 1'b0;
  int    cur = 0;

  // UART: a frame keeps tx_busy high for a fixed or random number of cycles.
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= busy_rand ? int'($urandom_range(1, 12)) : busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Requesters: valid/data/last held until accepted, random idle gaps between beats.
  initial begin : drv
    logic [1:0] hs;
    logic       rs;
    int         gap [2];
    int         n;
    beat_t      b;
    gap[0] = 0; gap[1] = 0; drv_d[0] = 8'h00; drv_d[1] = 8'h00;
    forever begin
      @(negedge clk);
      hs = drv_v & {bus.req1_ready, bus.req0_ready};
      rs = rst;
      @(posedge clk); #1;
      if (rs) begin
        drv_q0.delete(); drv_q1.delete(); drv_v = 2'b00;
      end else begin
        if (hs[0]) void'(drv_q0.pop_front());
        if (hs[1]) void'(drv_q1.pop_front());
        for (int i = 0; i < 2; i++) begin
          n = (i == 0) ? drv_q0.size() : drv_q1.size();
          if (n == 0) drv_v[i] = 1'b0;
          else if (!drv_v[i] || hs[i]) begin
            if (gap[i] == 0) begin
              b = (i == 0) ? drv_q0[0] : drv_q1[0];
              drv_v[i] = 1'b1; drv_d[i] = b.data; drv_l[i] = b.last;
              gap[i] = int'($urandom_range(0, gap_max));
            end else begin
              drv_v[i] = 1'b0; gap[i] = gap[i] - 1;
            end
          end
        end
      end
    end
  end

  // Observer: logs grant/tx/err events and counts protocol-rule breaches.
  initial begin : mon
    logic [1:0] pg;
    logic       pv0, pv1, phs, prst;
    logic [7:0] pd;
    ev_t        e;
    pg = 2'b00; pv0 = 1'b0; pv1 = 1'b0; phs = 1'b0; prst = 1'b1; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && !prst) begin
        e.grant = bus.grant; e.data = bus.tx_data; e.v0 = pv0; e.v1 = pv1;
        if (pg == 2'b00 && bus.grant != 2'b00) begin e.kind = 0; ev_q.push_back(e); end
        if (bus.tx_start) begin e.kind = 1; ev_q.push_back(e); tx_cnt++; end
        if (bus.arb_err) begin e.kind = 2; ev_q.push_back(e); err_pulses++; end
        if (bus.tx_start !== phs) lat_bad++;
        if (bus.tx_data !== pd && !phs) data_bad++;
        if ((bus.req0_ready && !bus.grant[0]) || (bus.req1_ready && !bus.grant[1])) ready_bad++;
        if ((bus.req0_ready || bus.req1_ready) && bus.tx_busy) ready_bad++;
      end
      pg = bus.grant; pv0 = bus.req0_valid; pv1 = bus.req1_valid; pd = bus.tx_data; prst = rst;
      phs = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int who, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    if (who == 0) begin drv_q0.push_back(b); exp_q0.push_back(b); end
    else begin drv_q1.push_back(b); exp_q1.push_back(b); end
  endtask

  task automatic add_pkt(input int who, input int len);
    for (int i = 0; i < len; i++) add_beat(who, 8'($urandom), (i == len - 1));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #2; rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #2; rst = 1'b0;
    ev_q.delete(); exp_q0.delete(); exp_q1.delete();
    fav1 = 1'b0; in_pkt = 1'b0; cur = 0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (n < limit && !(drv_q0.size() == 0 && drv_q1.size() == 0 && drv_v == 2'b00 &&
                          bus.grant == 2'b00 && !bus.tx_busy)) begin
      @(negedge clk); n++;
    end
    check({tag, "_done_in_time"}, 32'(n < limit), 1);
  endtask

  // Packet-level model: whole packets per owner, round robin on ties, bytes in enqueue order.
  task automatic process_log(input bit check_left);
    ev_t   e;
    beat_t b;
    int    n;
    while (ev_q.size() != 0) begin
      e = ev_q.pop_front();
      if (e.kind == 0) begin
        check("rr_not_mid_packet", 32'(in_pkt), 0);
        check("rr_some_valid", 32'(e.v0 | e.v1), 1);
        if (e.v0 && e.v1) cur = fav1 ? 1 : 0;
        else cur = e.v1 ? 1 : 0;
        check("rr_grant", 32'(e.grant), (cur == 0) ? 1 : 2);
      end else if (e.kind == 1) begin
        check("tx_owner", 32'(e.grant), (cur == 0) ? 1 : 2);
        n = (cur == 0) ? exp_q0.size() : exp_q1.size();
        check("tx_byte_pending", 32'(n != 0), 1);
        if (n != 0) begin
          if (cur == 0) b = exp_q0.pop_front();
          else b = exp_q1.pop_front();
          check("tx_data", 32'(e.data), 32'(b.data));
          in_pkt = !b.last;
          if (b.last) fav1 = (cur == 0);
        end
      end else begin
        fav1 = (cur == 0); in_pkt = 1'b0;
      end
    end
    if (check_left) begin
      check("left_req0", exp_q0.size(), 0);
      check("left_req1", exp_q1.size(), 0);
    end
  endtask

  task automatic check_rules(input string tag);
    check({tag, "_ready_rules"}, ready_bad, 0);
    check({tag, "_start_latency"}, lat_bad, 0);
    check({tag, "_tx_data_stable"}, data_bad, 0);
  endtask

  initial begin : main
    int n, bad, bad2, base;
    // Reset state
    do_reset(3);
    @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_req0_ready", 32'(bus.req0_ready), 0);
    check("rst_req1_ready", 32'(bus.req1_ready), 0);
    check("rst_arb_err", 32'(bus.arb_err), 0);

    // Three-byte packet from req0, minimum start latency from idle
    @(posedge clk); #2;
    busy_len = 10; gap_max = 0;
    add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b0); add_beat(0, 8'h33, 1'b1);
    n = 0;
    while (!bus.req0_valid && n < 20) begin @(negedge clk); n++; end
    check("lat_valid_seen", 32'(bus.req0_valid), 1);
    n = 0;
    while (!bus.tx_start && n < 20) begin @(negedge clk); n++; end
    check("lat_idle_to_start", n, 2);
    check("lat_first_byte", 32'(bus.tx_data), 32'h11);
    wait_idle(300, "pkt3");
    process_log(1'b1);
    check("pkt3_grant_released", 32'(bus.grant), 0);
    check_rules("pkt3");

    // Simultaneous requests after reset: req0 first, then alternate
    do_reset(1);
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(0, 2); add_pkt(1, 2);
    n = 0;
    while (bus.grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check("rr_first_is_req0", 32'(bus.grant), 1);
    wait_idle(500, "rr");
    process_log(1'b1);
    check_rules("rr");

    // req0 arrives while req1 is mid-packet
    @(posedge clk); #2;
    base = tx_cnt;
    add_pkt(1, 4);
    n = 0;
    while (tx_cnt < base + 2 && n < 200) begin @(negedge clk); n++; end
    check("mid_two_sent", tx_cnt - base, 2);
    @(posedge clk); #2;
    add_pkt(0, 2);
    n = 0;
    while (bus.grant != 2'b01 && n < 200) begin @(negedge clk); n++; end
    check("mid_req0_after_req1_packet", tx_cnt - base, 4);
    wait_idle(300, "mid");
    process_log(1'b1);
    check_rules("mid");

    // Random traffic, random frame lengths and gaps
    busy_rand = 1'b1; gap_max = 3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      add_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 25)) @(posedge clk);
    end
    wait_idle(5000, "rand");
    process_log(1'b1);
    check_rules("rand");

    // Reset while a frame is in flight: no grant until the UART goes idle
    busy_rand = 1'b0; busy_len = 30; gap_max = 0;
    do_reset(1);
    add_pkt(0, 2);
    n = 0;
    while (!bus.tx_start && n < 20) begin @(negedge clk); n++; end
    check("inflight_started", 32'(bus.tx_start), 1);
    process_log(1'b0);
    do_reset(1);
    @(negedge clk);
    check("inflight_rst_grant", 32'(bus.grant), 0);
    check("inflight_rst_tx_start", 32'(bus.tx_start), 0);
    check("inflight_rst_tx_data", 32'(bus.tx_data), 0);
    check("inflight_busy_kept", 32'(bus.tx_busy), 1);
    @(posedge clk); #2;
    add_beat(1, 8'h5A, 1'b1);
    bad = 0; n = 0;
    while (bus.tx_busy && n < 100) begin
      @(negedge clk); n++;
      if (bus.grant != 2'b00 && bus.tx_busy) bad++;
    end
    check("inflight_no_grant_while_busy", bad, 0);
    wait_idle(200, "inflight");
    process_log(1'b1);
    check_rules("inflight");

    // Granted requester stalls mid-packet while req1 waits
    busy_len = 10;
    do_reset(1);
    add_beat(0, 8'hAA, 1'b0);
    n = 0;
    while (!bus.tx_start && n < 20) begin @(negedge clk); n++; end
    check("stall_first_start", 32'(bus.tx_start), 1);
    @(posedge clk); #2;
    add_beat(1, 8'h5A, 1'b1);
`ifdef TX_ARB_TIMEOUT_EN
    n = 0;
    while (!bus.tx_busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (bus.tx_busy && n < 50) begin @(negedge clk); n++; end
    check("to_frame_done", 32'(bus.tx_busy), 0);
    repeat (TO_CYC) @(negedge clk);
    check("to_no_err_before_limit", 32'(bus.arb_err), 0);
    check("to_grant_before_limit", 32'(bus.grant), 1);
    @(negedge clk);
    check("to_err_pulse", 32'(bus.arb_err), 1);
    check("to_grant_dropped", 32'(bus.grant), 0);
    @(negedge clk);
    check("to_err_one_cycle", 32'(bus.arb_err), 0);
    wait_idle(200, "to");
    process_log(1'b1);
    check("to_err_count", err_pulses, 1);
    check_rules("to");
`else
    bad = 0; bad2 = 0;
    repeat (5000) begin
      @(negedge clk);
      if (bus.grant != 2'b01) bad++;
      if (bus.arb_err) bad2++;
    end
    check("hold_grant_kept", bad, 0);
    check("hold_no_arb_err", bad2, 0);
    process_log(1'b0);
    check("hold_err_count", err_pulses, 0);
    check_rules("hold");
    do_reset(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
